// File: rtl/pfb_input_commutator.sv
`default_nettype none
// ============================================================================
// Module  : pfb_input_commutator
// Brief   : Tags a raw complex AXI-stream with polyphase commutator indices
//           (M-1 down to 0, tlast on phase 0) behind a 2-entry skid buffer.
//           Optional macro PFB_COMMUTATOR_FRAME_CNT_EN adds frame_cnt and
//           frame_overrun status outputs.
// Revision: 1.0 - initial release
// ============================================================================
module pfb_input_commutator #(
    parameter int DATA_WIDTH  = 32,
    parameter int PHASE_WIDTH = 11,
    parameter int NPH_WIDTH   = 12
) (
    input  logic                   clk,
    input  logic                   sync_reset_n,
    input  logic [NPH_WIDTH-1:0]   num_phases,
    input  logic                   s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
    output logic                   s_axis_tready,
    output logic                   m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic [PHASE_WIDTH-1:0] m_axis_phase,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready,
    output logic                   cfg_err
`ifdef PFB_COMMUTATOR_FRAME_CNT_EN
    ,
    output logic [31:0]            frame_cnt,
    output logic                   frame_overrun
`endif
);

    localparam logic [NPH_WIDTH-1:0]   c_M_MIN  = NPH_WIDTH'(2);
    localparam logic [NPH_WIDTH-1:0]   c_M_MAX  = NPH_WIDTH'(1) << PHASE_WIDTH;
    localparam logic [NPH_WIDTH-1:0]   c_NPH_ONE = NPH_WIDTH'(1);
    localparam logic [PHASE_WIDTH-1:0] c_PH_ONE = PHASE_WIDTH'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic f_cfg_valid(input logic [NPH_WIDTH-1:0] m);
        return (m >= c_M_MIN) && (m <= c_M_MAX) && ((m & (m - c_NPH_ONE)) == '0);
    endfunction

    state_t                 r_state;
    logic [NPH_WIDTH-1:0]   r_m_reg;
    logic [PHASE_WIDTH-1:0] r_phase_cnt;
    logic                   r_cfg_err;
    logic                   r_s_ready;

    logic                   r_out_valid;
    logic [DATA_WIDTH-1:0]  r_out_data;
    logic [PHASE_WIDTH-1:0] r_out_phase;
    logic                   r_out_last;

    logic                   r_skid_valid;
    logic [DATA_WIDTH-1:0]  r_skid_data;
    logic [PHASE_WIDTH-1:0] r_skid_phase;
    logic                   r_skid_last;

    logic                   w_accept;
    logic                   w_out_free;
    logic [PHASE_WIDTH-1:0] w_cur_phase;
    logic                   w_cur_last;
    logic                   w_resample;
    logic [NPH_WIDTH-1:0]   w_m_next;
    logic                   w_m_next_valid;
    logic                   w_skid_valid_next;

    assign w_accept   = s_axis_tvalid & r_s_ready;
    assign w_out_free = ~r_out_valid | m_axis_tready;

    // The frame's first beat in IDLE takes M-1 directly from the latched M.
    assign w_cur_phase = (r_state == ST_IDLE) ? (r_m_reg[PHASE_WIDTH-1:0] - c_PH_ONE)
                                              : r_phase_cnt;
    assign w_cur_last  = (w_cur_phase == '0);

    // M is only re-latched while idle or at a frame boundary.
    assign w_resample     = ((r_state == ST_IDLE) & ~w_accept) | (w_accept & w_cur_last);
    assign w_m_next       = w_resample ? num_phases : r_m_reg;
    assign w_m_next_valid = f_cfg_valid(w_m_next);

    // Skid drains whenever the output frees; it only fills while the output stalls.
    always_comb begin
        w_skid_valid_next = r_skid_valid;
        if (w_out_free) begin
            w_skid_valid_next = 1'b0;
        end else if (w_accept) begin
            w_skid_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge sync_reset_n) begin
        if (!sync_reset_n) begin
            r_state      <= ST_IDLE;
            r_m_reg      <= '0;
            r_phase_cnt  <= '0;
            r_cfg_err    <= 1'b0;
            r_s_ready    <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_phase  <= '0;
            r_out_last   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_phase <= '0;
            r_skid_last  <= 1'b0;
        end else begin
            r_m_reg      <= w_m_next;
            r_cfg_err    <= ~w_m_next_valid;
            r_s_ready    <= ~w_skid_valid_next & w_m_next_valid;
            r_skid_valid <= w_skid_valid_next;

            if (w_accept) begin
                if (w_cur_last) begin
                    r_phase_cnt <= w_m_next[PHASE_WIDTH-1:0] - c_PH_ONE;
                    r_state     <= w_m_next_valid ? ST_RUN : ST_IDLE;
                end else begin
                    r_phase_cnt <= w_cur_phase - c_PH_ONE;
                    r_state     <= ST_RUN;
                end
            end

            if (w_out_free) begin
                if (r_skid_valid) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= r_skid_data;
                    r_out_phase <= r_skid_phase;
                    r_out_last  <= r_skid_last;
                end else if (w_accept) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= s_axis_tdata;
                    r_out_phase <= w_cur_phase;
                    r_out_last  <= w_cur_last;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_accept) begin
                r_skid_data  <= s_axis_tdata;
                r_skid_phase <= w_cur_phase;
                r_skid_last  <= w_cur_last;
            end
        end
    end

    assign s_axis_tready = r_s_ready;
    assign m_axis_tvalid = r_out_valid;
    assign m_axis_tdata  = r_out_data;
    assign m_axis_phase  = r_out_phase;
    assign m_axis_tlast  = r_out_last;
    assign cfg_err       = r_cfg_err;

`ifdef PFB_COMMUTATOR_FRAME_CNT_EN
    logic [31:0]          r_frame_cnt;
    logic                 r_frame_overrun;
    logic [NPH_WIDTH:0]   r_stall_cnt;
    logic [NPH_WIDTH:0]   w_stall_inc;
    logic [NPH_WIDTH:0]   w_stall_limit;

    assign w_stall_inc   = r_stall_cnt + (NPH_WIDTH + 1)'(1);
    assign w_stall_limit = {r_m_reg, 1'b0};

    always_ff @(posedge clk or negedge sync_reset_n) begin
        if (!sync_reset_n) begin
            r_frame_cnt     <= '0;
            r_frame_overrun <= 1'b0;
            r_stall_cnt     <= '0;
        end else begin
            if (r_out_valid & m_axis_tready & r_out_last) begin
                r_frame_cnt <= r_frame_cnt + 32'd1;
            end
            // Stall run length saturates once the overrun flag is raised.
            if (r_out_valid & ~m_axis_tready) begin
                if (w_stall_inc >= w_stall_limit) begin
                    r_frame_overrun <= 1'b1;
                end else begin
                    r_stall_cnt <= w_stall_inc;
                end
            end else begin
                r_stall_cnt <= '0;
            end
        end
    end

    assign frame_cnt     = r_frame_cnt;
    assign frame_overrun = r_frame_overrun;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pfb_input_commutator.sv
`default_nettype none
// ============================================================================
// Module  : tb_pfb_input_commutator
// Brief   : Directed self-checking bench for pfb_input_commutator.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pfb_input_commutator;

    logic        clk;
    logic        rst_n;
    logic [11:0] num_phases;
    logic        s_tvalid;
    logic [31:0] s_tdata;
    logic        s_tready;
    logic        m_tvalid;
    logic [31:0] m_tdata;
    logic [10:0] m_phase;
    logic        m_tlast;
    logic        m_tready;
    logic        cfg_err;
`ifdef PFB_COMMUTATOR_FRAME_CNT_EN
    logic [31:0] frame_cnt;
    logic        frame_overrun;
`endif

    int checks = 0;
    int errors = 0;
    int test_id = 0;
    logic [31:0] data_base = '0;
    int acc_cnt, out_cnt;
    int first_acc, first_out, bubbles;

    pfb_input_commutator #(
        .DATA_WIDTH (32),
        .PHASE_WIDTH(11),
        .NPH_WIDTH  (12)
    ) dut (
        .clk          (clk),
        .sync_reset_n (rst_n),
        .num_phases   (num_phases),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tdata (s_tdata),
        .s_axis_tready(s_tready),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tdata (m_tdata),
        .m_axis_phase (m_phase),
        .m_axis_tlast (m_tlast),
        .m_axis_tready(m_tready),
        .cfg_err      (cfg_err)
`ifdef PFB_COMMUTATOR_FRAME_CNT_EN
        ,
        .frame_cnt    (frame_cnt),
        .frame_overrun(frame_overrun)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hand-derived phase order for each directed scenario.
    function automatic int exp_phase(input int k);
        case (test_id)
            1, 5:    return 7 - (k % 8);
            2:       return 3 - (k % 4);
            3:       return (k < 8) ? (7 - k) : (15 - ((k - 8) % 16));
            4:       return 2047 - k;
            6, 7:    return 1 - (k % 2);
            default: return 0;
        endcase
    endfunction

    task automatic do_reset(input logic [11:0] nph);
        rst_n      = 1'b0;
        s_tvalid   = 1'b0;
        s_tdata    = '0;
        m_tready   = 1'b0;
        num_phases = nph;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Streams nbeats consecutive words; checks order, tags, stall stability
    // and that input backpressure appears only when two beats are in flight.
    task automatic stream(input int nbeats, input int rdy_pct, input int max_cycles);
        int          cyc = 0;
        logic        prev_stall = 1'b0;
        logic [31:0] pd = '0;
        logic [10:0] pp = '0;
        logic        pl = 1'b0;
        acc_cnt   = 0;
        out_cnt   = 0;
        first_acc = -1;
        first_out = -1;
        bubbles   = 0;
        while ((out_cnt < nbeats) && (cyc < max_cycles)) begin
            s_tvalid = (acc_cnt < nbeats);
            s_tdata  = data_base + 32'(acc_cnt);
            m_tready = ($urandom_range(99) < rdy_pct);
            if (prev_stall) begin
                chk("stall_valid", m_tvalid, 1'b1);
                chk("stall_data", m_tdata, pd);
                chk("stall_phase", m_phase, pp);
                chk("stall_last", m_tlast, pl);
            end
            chk("ready_vs_skid", s_tready, ((acc_cnt - out_cnt) < 2) && !cfg_err);
            if (first_out < 0 && m_tvalid) first_out = cyc;
            if (first_out >= 0 && !m_tvalid) bubbles++;
            if (m_tvalid && m_tready) begin
                chk("out_data", m_tdata, data_base + 32'(out_cnt));
                chk("out_phase", m_phase, exp_phase(out_cnt));
                chk("out_last", m_tlast, exp_phase(out_cnt) == 0);
                out_cnt++;
            end
            if (s_tvalid && s_tready) begin
                if (first_acc < 0) first_acc = cyc;
                acc_cnt++;
                if (test_id == 3 && acc_cnt == 3) num_phases = 12'd16;
                if (test_id == 6 && acc_cnt == 1) num_phases = 12'd3;
            end
            prev_stall = m_tvalid && !m_tready;
            pd = m_tdata;
            pp = m_phase;
            pl = m_tlast;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("stream_complete", out_cnt, nbeats);
        s_tvalid = 1'b0;
    endtask

    initial begin
        // Reset values, M=8 streaming with no backpressure
        test_id    = 1;
        rst_n      = 1'b0;
        num_phases = 12'd8;
        s_tvalid   = 1'b0;
        s_tdata    = '0;
        m_tready   = 1'b0;
        #12;
        chk("rst_s_tready", s_tready, 1'b0);
        chk("rst_m_tvalid", m_tvalid, 1'b0);
        chk("rst_m_tdata", m_tdata, 32'h0);
        chk("rst_m_phase", m_phase, 11'h0);
        chk("rst_m_tlast", m_tlast, 1'b0);
        chk("rst_cfg_err", cfg_err, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("pre_edge_s_tready", s_tready, 1'b0);
        @(posedge clk);
        #1;
        chk("first_edge_s_tready", s_tready, 1'b1);
        chk("first_edge_cfg_err", cfg_err, 1'b0);
        data_base = 32'h0;
        stream(24, 100, 200);
        chk("latency", first_out - first_acc, 1);
        chk("bubbles", bubbles, 0);

        // M=4 with 50% downstream ready
        test_id = 2;
        do_reset(12'd4);
        data_base = 32'h1000;
        stream(1000, 50, 6000);

        // M change mid-frame takes effect at the next frame boundary
        test_id = 3;
        do_reset(12'd8);
        data_base = 32'h2000;
        stream(24, 100, 200);

        // Invalid M at reset release, then M=2048
        test_id = 4;
        do_reset(12'd6);
        chk("bad_cfg_err", cfg_err, 1'b1);
        chk("bad_cfg_ready", s_tready, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("bad_cfg_err_hold", cfg_err, 1'b1);
        chk("bad_cfg_ready_hold", s_tready, 1'b0);
        num_phases = 12'd2048;
        @(posedge clk);
        #1;
        chk("m2048_cfg_err", cfg_err, 1'b0);
        chk("m2048_ready", s_tready, 1'b1);
        data_base = 32'h3000;
        stream(4, 100, 50);

        // Invalid M picked up at the frame boundary returns to IDLE
        test_id = 6;
        do_reset(12'd2);
        data_base = 32'h4000;
        stream(2, 100, 50);
        chk("boundary_cfg_err", cfg_err, 1'b1);
        chk("boundary_ready", s_tready, 1'b0);

        // Asynchronous reset with the skid buffer full
        test_id = 5;
        do_reset(12'd8);
        s_tvalid = 1'b1;
        s_tdata  = 32'h5000;
        @(posedge clk);
        #1 s_tdata = 32'h5001;
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        chk("skid_full_ready", s_tready, 1'b0);
        chk("skid_full_valid", m_tvalid, 1'b1);
        chk("skid_full_data", m_tdata, 32'h5000);
        chk("skid_full_phase", m_phase, 11'd7);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ready", s_tready, 1'b0);
        chk("async_rst_valid", m_tvalid, 1'b0);
        chk("async_rst_data", m_tdata, 32'h0);
        chk("async_rst_phase", m_phase, 11'h0);
        chk("async_rst_last", m_tlast, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        data_base = 32'h5100;
        stream(3, 100, 50);

`ifdef PFB_COMMUTATOR_FRAME_CNT_EN
        // Frame counting and sticky overrun with M=2
        test_id = 7;
        do_reset(12'd2);
        chk("fc_reset", frame_cnt, 32'd0);
        chk("ovr_reset", frame_overrun, 1'b0);
        data_base = 32'h6000;
        stream(20, 100, 100);
        chk("fc_ten", frame_cnt, 32'd10);
        chk("ovr_clear", frame_overrun, 1'b0);
        s_tvalid = 1'b1;
        s_tdata  = 32'h6100;
        m_tready = 1'b0;
        @(posedge clk);
        #1 s_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("ovr_three_stalls", frame_overrun, 1'b0);
        @(posedge clk);
        #1;
        chk("ovr_four_stalls", frame_overrun, 1'b1);
        m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("ovr_sticky", frame_overrun, 1'b1);
        chk("ovr_drained", m_tvalid, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pfb_input_commutator.md
Name: pfb_input_commutator

Overview:
- Feeds the M-path polyphase filter bank input stream.
- Takes a raw complex sample AXI-stream and tags each sample with its commutator phase index, counting M-1 down to 0.
- Asserts tlast on the phase-0 sample.
- Provides full-throughput registered backpressure through a 2-entry skid buffer, so the filter bank's almost-full-driven tready never drops data.

Parameters:
- DATA_WIDTH, 32, sample width: I in [31:16], Q in [15:0].
- PHASE_WIDTH, 11, phase index width; the maximum M is 2^PHASE_WIDTH.
- NPH_WIDTH, 12, width of num_phases; equals PHASE_WIDTH+1.

Ports:
- clk  in  1  single clock.
- sync_reset_n  in  1  asynchronous active-low reset.
- num_phases  in  NPH_WIDTH  requested M; must be a power of two, 2..2048.
- s_axis_tvalid  in  1  raw sample valid.
- s_axis_tdata  in  DATA_WIDTH  raw sample.
- s_axis_tready  out  1  raw sample ready; registered.
- m_axis_tvalid  out  1  tagged sample valid.
- m_axis_tdata  out  DATA_WIDTH  tagged sample.
- m_axis_phase  out  PHASE_WIDTH  phase index of the current m_axis beat.
- m_axis_tlast  out  1  high on the phase-0 beat.
- m_axis_tready  in  1  downstream ready.
- cfg_err  out  1  latched num_phases is invalid.

Behaviour:
- Reset (asynchronous, active-low): all outputs 0, skid buffer empty, state IDLE, phase counter 0, latched M = 0.
- s_axis_tready first rises on the first clk edge after reset is released, provided configuration is valid.
- Config check: valid when num_phases is a power of two with 2 <= num_phases <= 2^PHASE_WIDTH.
  - In IDLE, num_phases is sampled every cycle into m_reg.
  - cfg_err is registered from the validity of m_reg.
  - While cfg_err = 1, s_axis_tready = 0.
- States:
  - IDLE: waits for the first accepted input beat (s_axis_tvalid & s_axis_tready). That beat takes phase m_reg-1; if m_reg-1 = 0 it also takes tlast=1. The next state is RUN.
  - RUN:
    - Each accepted beat takes phase_cnt, and phase_cnt then decrements.
    - The beat with phase_cnt = 0 takes tlast=1.
    - After that beat, phase_cnt reloads to m_reg-1.
    - num_phases is re-sampled into m_reg only at the phase-0 acceptance, so changes take effect on the next frame boundary; a mid-frame change is ignored until then.
    - If the re-sampled value is invalid, the next state is IDLE, with cfg_err=1 the following cycle and s_axis_tready=0.
- Phase arithmetic: unsigned modulo 2^PHASE_WIDTH; m_reg-1 is taken on PHASE_WIDTH bits, so M=2048 gives 2047.
- Pipelining: main output register plus one skid register.
  - s_axis_tready = ~skid_full, registered.
  - A beat accepted while the output holds an unconsumed beat goes to skid.
  - On m_axis_tready, the skid entry moves to the output.
  - Latency from input acceptance to m_axis_tvalid is 1 cycle.
  - Sustained throughput is 1 beat/cycle when m_axis_tready = 1.
- Handshake rules:
  - m_axis_tdata, m_axis_phase and m_axis_tlast are stable while m_axis_tvalid=1 and m_axis_tready=0.
  - m_axis_tvalid never drops without a transfer.
- Simultaneous events:
  - Output consumed while a new input is accepted in the same cycle: the new beat goes directly to the output register; skid stays empty.
  - Skid full with m_axis_tready=1: skid moves to output and s_axis_tready reasserts next cycle.
- Reset mid-frame: the buffered beats are discarded and the first beat after reset restarts at phase M-1.
- m_axis_phase ordering (M-1 down to 0) matches the filter bank arm-loading order; the tlast beat corresponds to phase 0.

Optional Feature:
- Macro PFB_COMMUTATOR_FRAME_CNT_EN.
- When defined:
  - Adds output port frame_cnt [31:0], reset to 0.
  - frame_cnt increments on every m_axis transfer with tlast=1 and wraps from 0xFFFFFFFF to 0.
  - Adds output port frame_overrun, a sticky bit set when m_axis_tready stays low for 2*M consecutive cycles while m_axis_tvalid=1; cleared only by reset.
- When undefined: neither port exists, and there is no counter logic.

Test Plan:
- num_phases=8, continuous valid, m_axis_tready=1, 24 samples 0..23 -> phases 7,6,...,0 repeating three times.
  - tlast on samples 7, 15 and 23.
  - m_axis_tvalid first high 1 cycle after the first acceptance.
  - No bubbles.
- num_phases=4, random m_axis_tready at 50% duty over 1000 beats -> no loss or duplication; data and phase match the reference order; outputs stable during stalls; s_axis_tready low only while the skid is full.
- num_phases switched from 8 to 16 after the 3rd beat of a frame -> the current frame completes with 8 phases; the next frame starts at phase 15.
- num_phases=6 at reset release -> cfg_err=1 and s_axis_tready=0; changing to 2048 -> cfg_err clears and the first beat has phase 2047.
- Assert sync_reset_n low asynchronously mid-frame with the skid full -> all outputs 0 immediately, with no clk edge needed; after release the first beat has phase M-1.
- With PFB_COMMUTATOR_FRAME_CNT_EN defined, M=2, 10 frames -> frame_cnt=10; with m_axis_tready held low for 4 cycles -> frame_overrun=1 and sticky.
